// File: rtl/reg_mem_arbiter.sv
// reg_mem_arbiter: two-requester round-robin sequencer in front of the
// single-port reg_mem. Each accepted request spends one cycle in ISSUE,
// where reg_mem performs the access on the closing edge, and one cycle in
// RESP, where the registered memory output is captured for the owner.
// All outputs come straight from flops.
module reg_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // requester A (fetch side)
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_BITS-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_done,
    output logic [DATA_WIDTH-1:0] a_rdata,
    // requester B (load/store side)
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_BITS-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_done,
    output logic [DATA_WIDTH-1:0] b_rdata,
    // reg_mem side
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    last_grant_r;   // 1'b0 = A was granted last, 1'b1 = B
    logic                    owner_b_r;      // requester owning the access in flight
    logic                    we_r;           // latched direction, survives mem_wen drop in RESP
    logic                    a_gnt_r;
    logic                    b_gnt_r;
    logic                    a_done_r;
    logic                    b_done_r;
    logic [DATA_WIDTH-1:0]   a_rdata_r;
    logic [DATA_WIDTH-1:0]   b_rdata_r;
    logic [ADDR_BITS-1:0]    mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic                    mem_wen_r;
    logic                    busy_r;

    logic                    arb_valid_s;
    logic                    arb_b_s;
    logic                    grant_now_s;
    logic                    sel_we_s;
    logic [ADDR_BITS-1:0]    sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

    // Round-robin pick: a lone requester wins; on a tie the port that was
    // not granted last wins, which gives strict alternation under contention.
    function automatic logic pick_b(input logic req_a, input logic req_b, input logic last_b);
        logic res;
        if (req_a && req_b) begin
            res = ~last_b;
        end else if (req_b) begin
            res = 1'b1;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    // Arbitration decision and winner's request fields for the next edge.
    always_comb begin
        arb_valid_s = a_req | b_req;
        arb_b_s     = pick_b(a_req, b_req, last_grant_r);
        if ((state_r == IDLE) || (state_r == RESP)) begin
            grant_now_s = arb_valid_s;
        end else begin
            grant_now_s = 1'b0;
        end
        if (arb_b_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_we;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
    end

    // Sequencer FSM with registered outputs; a grant in IDLE or RESP
    // overrides the default next state and starts a new ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_b_r    <= 1'b0;
            we_r         <= 1'b0;
            a_gnt_r      <= 1'b0;
            b_gnt_r      <= 1'b0;
            a_done_r     <= 1'b0;
            b_done_r     <= 1'b0;
            a_rdata_r    <= {DATA_WIDTH{1'b0}};
            b_rdata_r    <= {DATA_WIDTH{1'b0}};
            mem_addr_r   <= {ADDR_BITS{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
            mem_wen_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            a_gnt_r  <= 1'b0;
            b_gnt_r  <= 1'b0;
            a_done_r <= 1'b0;
            b_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_wen_r <= 1'b0;
                end
                ISSUE: begin
                    // reg_mem performs the access on this edge
                    state_r   <= RESP;
                    busy_r    <= 1'b1;
                    mem_wen_r <= 1'b0;
                end
                RESP: begin
                    // reg_mem data_out now holds the word read during ISSUE
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_wen_r <= 1'b0;
                    if (owner_b_r) begin
                        b_done_r <= 1'b1;
                        if (!we_r) begin
                            b_rdata_r <= mem_rdata;
                        end else begin
                            b_rdata_r <= b_rdata_r;
                        end
                    end else begin
                        a_done_r <= 1'b1;
                        if (!we_r) begin
                            a_rdata_r <= mem_rdata;
                        end else begin
                            a_rdata_r <= a_rdata_r;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    mem_wen_r <= 1'b0;
                end
            endcase
            if (grant_now_s) begin
                state_r      <= ISSUE;
                busy_r       <= 1'b1;
                owner_b_r    <= arb_b_s;
                last_grant_r <= arb_b_s;
                we_r         <= sel_we_s;
                mem_addr_r   <= sel_addr_s;
                mem_wdata_r  <= sel_wdata_s;
                mem_wen_r    <= sel_we_s;
                a_gnt_r      <= ~arb_b_s;
                b_gnt_r      <= arb_b_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign a_gnt     = a_gnt_r;
    assign b_gnt     = b_gnt_r;
    assign a_done    = a_done_r;
    assign b_done    = b_done_r;
    assign a_rdata   = a_rdata_r;
    assign b_rdata   = b_rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wen   = mem_wen_r;
    assign busy      = busy_r;

endmodule
